output_giver: RTL and testbench

Parallel-to-serial output stage for the cipher datapath. Captures one 32-bit result word (ciphertext) on a load strobe and streams it out as eight 4-bit nibbles, most-significant nibble first, under a valid/ready handshake. Nibble order matches the input taker, so nibble n here carries the same bit positions that arrived as plaintext nibble n.

---
 rtl/output_giver_pkg.sv | 16 +
 rtl/output_giver_if.sv | 25 ++
 rtl/output_giver.sv | 67 ++++++
 tb/tb_output_giver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_giver_pkg.sv
// Shared constants for the cipher datapath nibble streamers.
// Nibble order and state encoding are common to the input taker and output giver.
package output_giver_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned NUM_NIB = DATA_W / NIB_W;
  localparam int unsigned IDX_W   = $clog2(NUM_NIB);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/output_giver_if.sv
// Load / nibble-stream bundle between a word producer, the output giver and its sink.
interface output_giver_if;
  import output_giver_pkg::*;

  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              nib_ready;
  logic [NIB_W-1:0]  nib_out;
  logic              nib_valid;
  logic [IDX_W-1:0]  nib_idx;
  logic              last;
  logic              busy;
  logic              done;

  modport master (
    output data_in, load, nib_ready,
    input  nib_out, nib_valid, nib_idx, last, busy, done
  );

  modport slave (
    input  data_in, load, nib_ready,
    output nib_out, nib_valid, nib_idx, last, busy, done
  );

endinterface

// File: rtl/output_giver.sv
// Parallel-to-serial output stage: captures a result word on load and streams it
// MSB nibble first under valid/ready, then pulses done for one cycle.
module output_giver
  import output_giver_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  output_giver_if.slave  bus
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]    cnt_q,   cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // The final nibble is not shifted out, so the word is simply left in place for DONE.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          shreg_d = bus.data_in;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.nib_ready) begin
          if (cnt_q == IDX_W'(NUM_NIB - 1)) begin
            state_d = ST_DONE;
          end else begin
            shreg_d = shreg_q << NIB_W;
            cnt_d   = cnt_q + IDX_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode registered state only; nothing flows from inputs to outputs.
  assign bus.nib_out   = shreg_q[DATA_W-1 -: NIB_W];
  assign bus.nib_valid = (state_q == ST_SEND);
  assign bus.nib_idx   = cnt_q;
  assign bus.last      = (state_q == ST_SEND) && (cnt_q == IDX_W'(NUM_NIB - 1));
  assign bus.busy      = (state_q == ST_SEND) || (state_q == ST_DONE);
  assign bus.done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_output_giver.sv
// Directed bench for output_giver: nominal stream, backpressure, ignored loads,
// mid-word reset, back-to-back words and nibble-order round trip.
module tb_output_giver;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  output_giver_if bus();

  output_giver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nib_of(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = w >> (4 * (7 - i));
    return t[3:0];
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    bus.load = 1'b0;
    bus.nib_ready = 1'b0;
    bus.data_in = '0;
    step();
    step();
    total++;
    if ({bus.nib_out, bus.nib_valid, bus.nib_idx, bus.last, bus.busy, bus.done} !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {bus.nib_out, bus.nib_valid, bus.nib_idx, bus.last, bus.busy, bus.done}, 10'b0);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic;
    logic [31:0] w;
    logic [9:0]  got, exp;
    w = 32'hDEAD_BEEF;
    bus.data_in = w;
    bus.load = 1'b1;
    bus.nib_ready = 1'b1;
    step();
    bus.load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      got = {bus.nib_out, bus.nib_valid, bus.nib_idx, bus.last, bus.busy};
      exp = {nib_of(w, c - 1), 1'b1, 3'(c - 1), (c == 8), 1'b1};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL basic_cycle%0d got=%b exp=%b", c, got, exp);
      end
      step();
    end
    total++;
    if ({bus.nib_valid, bus.last, bus.busy, bus.done} !== 4'b0011) begin
      bad++;
      $display("FAIL basic_done got=%b exp=0011", {bus.nib_valid, bus.last, bus.busy, bus.done});
    end
    step();
    total++;
    if ({bus.nib_valid, bus.busy, bus.done} !== 3'b000) begin
      bad++;
      $display("FAIL basic_idle got=%b exp=000", {bus.nib_valid, bus.busy, bus.done});
    end
  endtask

  task automatic test_backpressure;
    int exp_idx [1:12] = '{0, 1, 1, 1, 1, 2, 2, 3, 4, 5, 6, 7};
    logic rdy [1:12] = '{1, 0, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    logic [7:0] got, exp;
    bus.data_in = 32'h0123_4567;
    bus.load = 1'b1;
    bus.nib_ready = 1'b1;
    step();
    bus.load = 1'b0;
    bus.data_in = 32'hFFFF_FFFF;
    for (int c = 1; c <= 12; c++) begin
      bus.nib_ready = rdy[c];
      got = {bus.nib_valid, bus.nib_idx, bus.nib_out};
      exp = {1'b1, 3'(exp_idx[c]), 4'(exp_idx[c])};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL bp_cycle%0d got=%h exp=%h", c, got, exp);
      end
      step();
    end
    total++;
    if ({bus.nib_valid, bus.done} !== 2'b01) begin
      bad++;
      $display("FAIL bp_done_cycle13 got=%b exp=01", {bus.nib_valid, bus.done});
    end
    bus.nib_ready = 1'b1;
    step();
  endtask

  task automatic test_load_while_busy;
    logic [31:0] w;
    w = 32'h1357_9BDF;
    bus.data_in = w;
    bus.load = 1'b1;
    bus.nib_ready = 1'b1;
    step();
    bus.load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 4) begin
        bus.load = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
      end else begin
        bus.load = 1'b0;
      end
      total++;
      if ({bus.nib_valid, bus.nib_out} !== {1'b1, nib_of(w, c - 1)}) begin
        bad++;
        $display("FAIL lwb_cycle%0d got=%h exp=%h", c, {bus.nib_valid, bus.nib_out},
                 {1'b1, nib_of(w, c - 1)});
      end
      step();
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL lwb_done got=%b exp=1", bus.done);
    end
    for (int c = 10; c <= 13; c++) begin
      step();
      total++;
      if ({bus.nib_valid, bus.busy} !== 2'b00) begin
        bad++;
        $display("FAIL lwb_not_queued_cycle%0d got=%b exp=00", c, {bus.nib_valid, bus.busy});
      end
    end
  endtask

  task automatic test_reset_mid_word;
    logic [31:0] w;
    bus.data_in = 32'hCAFE_F00D;
    bus.load = 1'b1;
    bus.nib_ready = 1'b1;
    step();
    bus.load = 1'b0;
    for (int c = 1; c <= 4; c++) step();
    total++;
    if (bus.nib_idx !== 3'd4) begin
      bad++;
      $display("FAIL rst_pre_idx got=%0d exp=4", bus.nib_idx);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if ({bus.nib_out, bus.nib_valid, bus.nib_idx, bus.last, bus.busy, bus.done} !== 10'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs got=%b exp=%b",
               {bus.nib_out, bus.nib_valid, bus.nib_idx, bus.last, bus.busy, bus.done}, 10'b0);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({bus.done, bus.nib_valid} !== 2'b00) begin
        bad++;
        $display("FAIL rst_no_done c=%0d got=%b exp=00", c, {bus.done, bus.nib_valid});
      end
    end
    w = 32'hA5A5_A5A5;
    bus.data_in = w;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      total++;
      if ({bus.nib_valid, bus.nib_out} !== {1'b1, nib_of(w, c - 1)}) begin
        bad++;
        $display("FAIL rst_reload_cycle%0d got=%h exp=%h", c, {bus.nib_valid, bus.nib_out},
                 {1'b1, nib_of(w, c - 1)});
      end
      step();
    end
    total++;
    if (bus.done !== 1'b1) begin
      bad++;
      $display("FAIL rst_reload_done got=%b exp=1", bus.done);
    end
    step();
  endtask

  task automatic test_back_to_back;
    int n_done;
    int first_done;
    int second_done;
    logic [4:0] exp;
    n_done = 0;
    first_done = -1;
    second_done = -1;
    bus.data_in = 32'h1111_1111;
    bus.load = 1'b1;
    bus.nib_ready = 1'b1;
    step();
    bus.data_in = 32'h2222_2222;
    for (int c = 1; c <= 20; c++) begin
      if (c >= 1 && c <= 8)        exp = 5'h11;
      else if (c >= 11 && c <= 18) exp = 5'h12;
      else                         exp = 5'h00;
      if (exp[4]) begin
        total++;
        if ({bus.nib_valid, bus.nib_out} !== exp) begin
          bad++;
          $display("FAIL b2b_cycle%0d got=%h exp=%h", c, {bus.nib_valid, bus.nib_out}, exp);
        end
      end else begin
        total++;
        if (bus.nib_valid !== 1'b0) begin
          bad++;
          $display("FAIL b2b_gap_cycle%0d valid=%b exp=0", c, bus.nib_valid);
        end
      end
      if (bus.done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c == 12) bus.load = 1'b0;
      step();
    end
    total++;
    if (n_done != 2 || first_done != 9 || second_done != 19) begin
      bad++;
      $display("FAIL b2b_done_count n=%0d at=%0d,%0d exp n=2 at=9,19", n_done, first_done, second_done);
    end
  endtask

  task automatic test_round_trip;
    logic [3:0]  pt [8] = '{4'h3, 4'h9, 4'hC, 4'h0, 4'h7, 4'hE, 4'h1, 4'h8};
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w = {w[27:0], pt[i]};
    bus.data_in = w;
    bus.load = 1'b1;
    bus.nib_ready = 1'b1;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if ({bus.nib_valid, bus.nib_idx, bus.nib_out} !== {1'b1, 3'(i), pt[i]}) begin
        bad++;
        $display("FAIL rt_nib%0d got=%h exp=%h", i, {bus.nib_valid, bus.nib_idx, bus.nib_out},
                 {1'b1, 3'(i), pt[i]});
      end
      step();
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_load_while_busy();
    test_reset_mid_word();
    test_back_to_back();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
